apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

APB requester that drives the configuration bus toward the config-register slaves. It accepts single read/write commands on a valid/ready command channel and runs one APB SETUP/ACCESS transfer per command. It returns read data and an error flag on a valid/ready response channel. It sits between the system-side control logic and up to SLV_NUM APB slaves, with one psel line per slave.

## Interface
- DATA_WIDTH, 32, APB data width
- ADDR_WIDTH, 10, APB address width
- SLV_NUM, 3, number of APB slaves, one psel bit each
- SEL_WIDTH, 2, width of slave index; 2^SEL_WIDTH >= SLV_NUM
- TIMEOUT_CYC, 16, maximum ACCESS cycles waited for pready; must be >= 2
- pclk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_slv  in  SEL_WIDTH  target slave index
- cmd_addr  in  ADDR_WIDTH  register address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  timeout or invalid slave index
- psel  out  SLV_NUM  one-hot APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pready  in  1  OR of slave ready signals
- prdata  in  DATA_WIDTH  muxed slave read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1, and only in IDLE.
  - On cmd_valid, latch write/slv/addr/wdata.
  - If cmd_slv >= SLV_NUM, go to RESP with rsp_err=1 and rsp_rdata=0. No bus activity.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): psel[cmd_slv]=1, penable=0, paddr/pwrite/pwdata driven from latched values. Next state is ACCESS.
- ACCESS:
  - psel held, penable=1.
  - The wait counter starts at 0 and increments each ACCESS cycle.
  - pready=1: complete. Capture prdata into rsp_rdata for reads (0 for writes), set rsp_err=0, go to RESP.
  - pready=0 with counter = TIMEOUT_CYC-1: abort. Set rsp_err=1, rsp_rdata=0, go to RESP.
- RESP:
  - psel=0, penable=0.
  - rsp_valid=1, and rsp_rdata/rsp_err stay stable until rsp_ready.
  - On rsp_ready, go to IDLE.
- pready is ignored outside ACCESS. A slave asserting pready early, during SETUP, has no effect.
- paddr/pwrite/pwdata hold their last values after a transfer; no return to 0.
- Reset mid-transfer: every output returns to its reset value immediately and the FSM goes to IDLE. The in-flight command is lost and produces no response.

## Timing
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=1 (state IDLE).
- Command accepted on edge N:
  - SETUP occupies cycle N+1.
  - First ACCESS cycle is N+2.
  - If pready is high in cycle N+1+k (k ≥ 1), rsp_valid is high from N+2+k.
- Minimum command-to-response latency is 3 cycles. A back-to-back command is accepted no sooner than the cycle after the rsp_valid & rsp_ready handshake.
- Against the registered-pready config slave:
  - Read: pready is already high in the first ACCESS cycle (k=1).
  - Write: pready first appears in the second ACCESS cycle (k=2).
- Timeout: rsp_valid with rsp_err=1 rises TIMEOUT_CYC+2 cycles after acceptance.
- Invalid slave index: rsp_valid rises in the cycle after acceptance.
- rsp_valid & rsp_ready and a new cmd_valid in the same cycle: the response completes and the FSM enters IDLE. The command is accepted in the next cycle, because cmd_ready is only asserted in IDLE.

## Structure
- Shared package apb_pkg holds:
  - the state enum {IDLE, SETUP, ACCESS, RESP}
  - the default TIMEOUT_CYC constant
  - the response-error encoding, reused by later APB masters.
- One natural sub-module, apb_wait_timer: the ACCESS cycle counter with clear/enable and a timeout flag, width $clog2(TIMEOUT_CYC).
- The FSM, command latch and response registers stay in the top.

## Test plan
- Write qos: slave 0 model with registered pready; cmd write slv=0 addr=0 wdata=1 -> psel=3'b001, one SETUP cycle, penable for 2 cycles, slave qos_en=1; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read way_en: slave preloaded way_en=3'b101; cmd read slv=0 addr=1 -> rsp_rdata=32'h5, rsp_err=0, 3 cycles after acceptance.
- Timeout: slave model holds pready=0; any command -> penable high for exactly 16 cycles, then psel=0, rsp_err=1, rsp_rdata=0.
- Invalid slave: cmd_slv=3 with SLV_NUM=3 -> psel stays 0 for the whole test; rsp_err=1 one cycle after acceptance.
- Response backpressure: rsp_ready held low for 5 cycles -> rsp_valid and data stable and cmd_ready=0 throughout; after the rsp handshake, the next command is accepted one cycle later.
- Reset in ACCESS: assert rst_b=0 while penable=1 -> psel, penable and rsp_valid drop asynchronously to 0; after release, cmd_ready=1 and no response appears.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, default timeout, response-error encoding.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int TIMEOUT_CYC_DEF = 16;

    // Error flag carried back on the response channel.
    typedef enum logic {
        APB_RSP_OK  = 1'b0,
        APB_RSP_ERR = 1'b1
    } apb_rsp_err_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response channels plus the APB bus of the bridge.
// valid/ready: a beat transfers on a rising pclk edge where valid and ready are both high;
// the source holds valid and its payload stable until that edge.
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int SLV_NUM    = 3,
    parameter int SEL_WIDTH  = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [SEL_WIDTH-1:0]  cmd_slv;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [SLV_NUM-1:0]    psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_slv, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_slv, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles; o_timeout flags the last cycle a transfer may wait for pready.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic pclk,
    input  logic rst_b,
    input  logic i_clear,
    input  logic i_en,
    output logic o_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge pclk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_timeout) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_timeout = (r_cnt == LAST);
endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one SETUP/ACCESS transfer per accepted command, result on the response channel.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int SLV_NUM     = 3,
    parameter int SEL_WIDTH   = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              pclk,
    input  logic              rst_b,
    apb_master_bridge_if.master bus,
    output apb_state_e        o_dbg_state
);
    apb_state_e            r_state;
    apb_state_e            w_next;
    logic [SEL_WIDTH-1:0]  r_slv;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  w_slv_ok;
    logic                  w_timeout;
    logic [SLV_NUM-1:0]    w_psel;

    // Extra bit keeps the compare correct when SLV_NUM == 2**SEL_WIDTH.
    assign w_slv_ok = ({1'b0, bus.cmd_slv} < (SEL_WIDTH + 1)'(SLV_NUM));

    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .pclk      (pclk),
        .rst_b     (rst_b),
        .i_clear   (r_state != ACCESS),
        .i_en      (r_state == ACCESS),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge pclk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.cmd_valid) w_next = w_slv_ok ? SETUP : RESP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (bus.pready || w_timeout) w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Bus-side fields load only for a valid slave so paddr/pwrite/pwdata keep the last real transfer.
    always_ff @(posedge pclk or negedge rst_b) begin
        if (!rst_b) begin
            r_slv    <= '0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (r_state == IDLE && bus.cmd_valid && w_slv_ok) begin
            r_slv    <= bus.cmd_slv;
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge pclk or negedge rst_b) begin
        if (!rst_b) begin
            r_rdata <= '0;
            r_err   <= APB_RSP_OK;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid && !w_slv_ok) begin
                        r_rdata <= '0;
                        r_err   <= APB_RSP_ERR;
                    end
                end
                ACCESS: begin
                    if (bus.pready) begin
                        r_rdata <= r_pwrite ? '0 : bus.prdata;
                        r_err   <= APB_RSP_OK;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= APB_RSP_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_psel = (r_state == SETUP || r_state == ACCESS) ? (SLV_NUM'(1) << r_slv) : '0;

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.psel      = w_psel;
    assign bus.penable   = (r_state == ACCESS);
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a registered-pready config slave model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SN = 3;
  localparam int SW = 2;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic rst_b = 1'b0;
  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLV_NUM(SN), .SEL_WIDTH(SW)) bus ();
  apb_state_e dbg_state;

  apb_master_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLV_NUM(SN), .SEL_WIDTH(SW), .TIMEOUT_CYC(TO)
  ) dut (
    .pclk(pclk),
    .rst_b(rst_b),
    .bus(bus.master),
    .o_dbg_state(dbg_state)
  );

  // ---------------- slave model ----------------
  // mode 0: registered pready (reads k=1, writes k=2); 1: never ready; 2: always ready
  int slave_mode = 0;
  logic r_sl_ready;
  logic [DW-1:0] smem [SN][16];
  logic written [SN][16];
  int rd_idx;
  logic [3:0] rd_a;

  function automatic int sel_idx(input logic [SN-1:0] s);
    int r = 0;
    for (int i = 0; i < SN; i++) if (s[i]) r = i;
    return r;
  endfunction

  function automatic logic [DW-1:0] preload(input int i, input int a);
    if (i == 0 && a == 1) return 32'h5;
    return 32'hC0DE_0000 | DW'(i << 8) | DW'(a);
  endfunction

  always @(posedge pclk or negedge rst_b) begin
    if (!rst_b) r_sl_ready <= 1'b0;
    else r_sl_ready <= (|bus.psel) && !r_sl_ready && (bus.pwrite ? bus.penable : !bus.penable);
  end

  always @(posedge pclk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < SN; i++)
        for (int j = 0; j < 16; j++) written[i][j] <= 1'b0;
    end else if ((|bus.psel) && bus.penable && bus.pready && bus.pwrite) begin
      smem[sel_idx(bus.psel)][bus.paddr[3:0]] <= bus.pwdata;
      written[sel_idx(bus.psel)][bus.paddr[3:0]] <= 1'b1;
    end
  end

  always_comb begin
    rd_idx = sel_idx(bus.psel);
    rd_a = bus.paddr[3:0];
    bus.pready = (slave_mode == 1) ? 1'b0 : (slave_mode == 2) ? 1'b1 : r_sl_ready;
    bus.prdata = '0;
    if (|bus.psel) bus.prdata = written[rd_idx][rd_a] ? smem[rd_idx][rd_a] : preload(rd_idx, int'(rd_a));
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] ref_mem [SN][16];
  logic [DW:0] exp_q[$];
  logic [AW-1:0] last_paddr;
  int checks = 0;
  int failures = 0;

  task automatic ref_reset();
    for (int i = 0; i < SN; i++)
      for (int j = 0; j < 16; j++) ref_mem[i][j] = preload(i, j);
    last_paddr = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input bit wr, input int slv, input int addr, input logic [DW-1:0] wd,
                         input int mode, input int hold);
    int lat, pen_cnt, setup_cnt, wait_cyc, exp_lat;
    logic [SN-1:0] seen_psel, exp_psel;
    bit field_bad;
    logic [DW:0] exp;
    logic [DW-1:0] rd0;
    logic err0;

    // expectation from the command rules
    if (slv >= SN) begin
      exp = {1'b1, 32'h0}; exp_lat = 1; exp_psel = '0;
    end else if (mode == 1) begin
      exp = {1'b1, 32'h0}; exp_lat = TO + 2; exp_psel = SN'(1) << slv;
    end else begin
      exp_psel = SN'(1) << slv;
      exp_lat = (mode == 2) ? 3 : (wr ? 4 : 3);
      if (wr) begin
        exp = {1'b0, 32'h0};
        ref_mem[slv][addr] = wd;
      end else begin
        exp = {1'b0, ref_mem[slv][addr]};
      end
    end
    if (slv < SN) last_paddr = AW'(addr);
    exp_q.push_back(exp);

    @(negedge pclk);
    slave_mode = mode;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_slv = SW'(slv);
    bus.cmd_addr = AW'(addr);
    bus.cmd_wdata = wd;
    wait_cyc = 0;
    while (!bus.cmd_ready && wait_cyc < 50) begin
      @(negedge pclk);
      wait_cyc++;
    end
    chk("cmd_ready_before_accept", bus.cmd_ready, 1);
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = $urandom_range(0, 1);
    bus.cmd_addr = AW'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_slv = SW'($urandom);

    lat = 1; pen_cnt = 0; setup_cnt = 0; seen_psel = '0; field_bad = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (|bus.psel) begin
        seen_psel |= bus.psel;
        if (bus.penable) pen_cnt++; else setup_cnt++;
        if (bus.paddr !== AW'(addr) || bus.pwrite !== wr || (wr && bus.pwdata !== wd)) field_bad = 1;
      end
      @(negedge pclk);
      lat++;
    end

    exp = exp_q.pop_front();
    chk("rsp_latency", lat, exp_lat);
    chk("rsp_rdata", bus.rsp_rdata, exp[DW-1:0]);
    chk("rsp_err", bus.rsp_err, exp[DW]);
    chk("psel_onehot", seen_psel, exp_psel);
    chk("setup_cycles", setup_cnt, (slv < SN) ? 1 : 0);
    chk("penable_cycles", pen_cnt, (slv < SN) ? exp_lat - 2 : 0);
    chk("bus_fields", field_bad, 0);
    chk("resp_psel_idle", {bus.psel, bus.penable}, 0);
    chk("resp_cmd_ready", bus.cmd_ready, 0);
    chk("paddr_hold", bus.paddr, last_paddr);

    rd0 = bus.rsp_rdata;
    err0 = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge pclk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_stable", {bus.rsp_err, bus.rsp_rdata}, {err0, rd0});
      chk("bp_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    bus.rsp_ready = 1'b0;
    chk("post_rsp_idle", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_rsp;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_slv = '0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    ref_reset();

    #1;
    chk("reset_psel_penable", {bus.psel, bus.penable}, 0);
    chk("reset_bus_fields", {bus.pwrite, bus.paddr, bus.pwdata}, 0);
    chk("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_state", dbg_state, IDLE);
    repeat (3) @(negedge pclk);
    rst_b = 1'b1;

    // write qos_en, read way_en
    run_cmd(1'b1, 0, 0, 32'h1, 0, 0);
    chk("slave_qos_en", smem[0][0][0], 1);
    run_cmd(1'b0, 0, 1, 32'h0, 0, 0);
    // timeout, invalid slave, backpressure, early pready
    run_cmd(1'b0, 1, 3, 32'h0, 1, 0);
    run_cmd(1'b1, 2, 4, 32'hDEAD_BEEF, 1, 0);
    run_cmd(1'b1, 3, 7, 32'h1234_5678, 0, 0);
    run_cmd(1'b0, 3, 2, 32'h0, 0, 0);
    run_cmd(1'b1, 2, 9, 32'hA5A5_0F0F, 0, 5);
    run_cmd(1'b0, 2, 9, 32'h0, 0, 5);
    run_cmd(1'b1, 1, 5, 32'h0BAD_F00D, 2, 0);
    run_cmd(1'b0, 1, 5, 32'h0, 2, 1);

    for (int i = 0; i < 24; i++) begin
      int mode;
      mode = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 4) == 0) ? 2 : 0);
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom, mode, $urandom_range(0, 3));
    end

    // reset while in ACCESS
    @(negedge pclk);
    slave_mode = 1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_slv = 2'd1;
    bus.cmd_addr = 10'h2A;
    bus.cmd_wdata = 32'hFFFF_0001;
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    chk("pre_reset_penable", bus.penable, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("async_rst_psel_penable", {bus.psel, bus.penable}, 0);
    chk("async_rst_rsp_valid", bus.rsp_valid, 0);
    chk("async_rst_bus_fields", {bus.pwrite, bus.paddr, bus.pwdata}, 0);
    chk("async_rst_cmd_ready", bus.cmd_ready, 1);
    ref_reset();
    @(negedge pclk);
    rst_b = 1'b1;
    slave_mode = 0;
    n_rsp = 0;
    repeat (25) begin
      @(negedge pclk);
      if (bus.rsp_valid) n_rsp++;
    end
    chk("no_rsp_after_reset", n_rsp, 0);
    chk("idle_after_reset", bus.cmd_ready, 1);

    run_cmd(1'b0, 0, 1, 32'h0, 0, 0);
    run_cmd(1'b1, 2, 6, 32'h7777_1111, 0, 2);
    run_cmd(1'b0, 2, 6, 32'h0, 0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
